// File: rtl/regfile_debug_port.sv
// regfile_debug_port: sequences debug-transport read/write commands through the
// register file's extra port while the core is halted. RF_DEBUG_DUMP_EN builds whole-file dump.
module regfile_debug_port
`ifdef RF_DEBUG_DUMP_EN
  #(parameter int DUMP_START = 0)
`endif
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        core_halted,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_dump,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_addr,
  output logic        rsp_error,
  output logic        rsp_last,
  output logic [4:0]  extra_addr,
  output logic        extra_write_enable,
  output logic [31:0] extra_write_data,
  input  logic [31:0] extra_read_data
);

`ifdef RF_DEBUG_DUMP_EN
  localparam bit         DUMP_EN    = 1'b1;
  localparam logic [4:0] DUMP_FIRST = 5'(DUMP_START);
`else
  localparam bit         DUMP_EN    = 1'b0;
  localparam logic [4:0] DUMP_FIRST = 5'd0;
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_RD_WAIT   = 3'd2,
    S_RD_CAP    = 3'd3,
    S_RESP      = 3'd4,
    S_DUMP_NEXT = 3'd5
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_cmd_dump, w_cmd_dump_next;
  logic [4:0]  r_extra_addr, w_extra_addr_next;
  logic [31:0] r_extra_wdata, w_extra_wdata_next;
  logic        r_rsp_valid, w_rsp_valid_next;
  logic [31:0] r_rsp_data, w_rsp_data_next;
  logic [4:0]  r_rsp_addr, w_rsp_addr_next;
  logic        r_rsp_error, w_rsp_error_next;
  logic        r_rsp_last, w_rsp_last_next;

  logic w_cmd_fire;
  logic w_reject;

  assign cmd_ready  = (r_state == S_IDLE);
  assign w_cmd_fire = cmd_valid && cmd_ready;
  // A running core, or a dump request in a build without dump, is refused straight from IDLE.
  assign w_reject   = !core_halted || (cmd_dump && !DUMP_EN);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state       <= S_IDLE;
      r_cmd_dump    <= 1'b0;
      r_extra_addr  <= '0;
      r_extra_wdata <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_addr    <= '0;
      r_rsp_error   <= 1'b0;
      r_rsp_last    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cmd_dump    <= w_cmd_dump_next;
      r_extra_addr  <= w_extra_addr_next;
      r_extra_wdata <= w_extra_wdata_next;
      r_rsp_valid   <= w_rsp_valid_next;
      r_rsp_data    <= w_rsp_data_next;
      r_rsp_addr    <= w_rsp_addr_next;
      r_rsp_error   <= w_rsp_error_next;
      r_rsp_last    <= w_rsp_last_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          if (w_reject)       w_state_next = S_RESP;
          else if (cmd_dump)  w_state_next = S_RD_WAIT;
          else if (cmd_write) w_state_next = S_WRITE;
          else                w_state_next = S_RD_WAIT;
        end
      end
      S_WRITE:   w_state_next = S_RESP;
      S_RD_WAIT: w_state_next = S_RD_CAP;
      S_RD_CAP:  w_state_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
`ifdef RF_DEBUG_DUMP_EN
          w_state_next = r_rsp_last ? S_IDLE : S_DUMP_NEXT;
`else
          w_state_next = S_IDLE;
`endif
        end
      end
`ifdef RF_DEBUG_DUMP_EN
      S_DUMP_NEXT: w_state_next = S_RD_WAIT;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_dump_next    = r_cmd_dump;
    w_extra_addr_next  = r_extra_addr;
    w_extra_wdata_next = r_extra_wdata;
    w_rsp_valid_next   = r_rsp_valid;
    w_rsp_data_next    = r_rsp_data;
    w_rsp_addr_next    = r_rsp_addr;
    w_rsp_error_next   = r_rsp_error;
    w_rsp_last_next    = r_rsp_last;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_fire) begin
          w_cmd_dump_next    = cmd_dump && DUMP_EN;
          w_extra_addr_next  = cmd_addr;
          w_extra_wdata_next = cmd_wdata;
          if (w_reject) begin
            w_rsp_valid_next = 1'b1;
            w_rsp_data_next  = '0;
            w_rsp_addr_next  = cmd_addr;
            w_rsp_error_next = 1'b1;
            w_rsp_last_next  = 1'b1;
          end else if (cmd_dump) begin
            w_extra_addr_next = DUMP_FIRST;
          end
        end
      end
      S_WRITE: begin
        w_rsp_valid_next = 1'b1;
        w_rsp_data_next  = '0;
        w_rsp_addr_next  = r_extra_addr;
        w_rsp_error_next = !core_halted;
        w_rsp_last_next  = 1'b1;
      end
      S_RD_CAP: begin
        w_rsp_valid_next = 1'b1;
        w_rsp_addr_next  = r_extra_addr;
        if (core_halted) begin
          w_rsp_data_next  = extra_read_data;
          w_rsp_error_next = 1'b0;
          w_rsp_last_next  = !r_cmd_dump || (r_extra_addr == 5'd31);
        end else begin
          w_rsp_data_next  = '0;
          w_rsp_error_next = 1'b1;
          w_rsp_last_next  = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_rsp_valid_next = 1'b0;
      end
`ifdef RF_DEBUG_DUMP_EN
      S_DUMP_NEXT: w_extra_addr_next = r_extra_addr + 5'd1;
`endif
      default: ;
    endcase
  end

  // The write strobe follows core_halted live so a halt drop during WRITE suppresses it.
  assign extra_write_enable = (r_state == S_WRITE) && core_halted;
  assign extra_addr         = r_extra_addr;
  assign extra_write_data   = r_extra_wdata;
  assign rsp_valid          = r_rsp_valid;
  assign rsp_data           = r_rsp_data;
  assign rsp_addr           = r_rsp_addr;
  assign rsp_error          = r_rsp_error;
  assign rsp_last           = r_rsp_last;

endmodule

// File: tb/tb_regfile_debug_port.sv
// Scoreboard bench for regfile_debug_port with a registered-read register file model.
// Dump scenarios are built when RF_DEBUG_DUMP_EN is defined.
module tb_regfile_debug_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_halted;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic        cmd_dump;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_addr;
  logic        rsp_error;
  logic        rsp_last;
  logic [4:0]  extra_addr;
  logic        extra_write_enable;
  logic [31:0] extra_write_data;
  logic [31:0] extra_read_data;

  always #5 clk = ~clk;

  regfile_debug_port dut (
    .CLK                (clk),
    .RSTn               (rst_n),
    .core_halted        (core_halted),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_write          (cmd_write),
    .cmd_dump           (cmd_dump),
    .cmd_addr           (cmd_addr),
    .cmd_wdata          (cmd_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_data           (rsp_data),
    .rsp_addr           (rsp_addr),
    .rsp_error          (rsp_error),
    .rsp_last           (rsp_last),
    .extra_addr         (extra_addr),
    .extra_write_enable (extra_write_enable),
    .extra_write_data   (extra_write_data),
    .extra_read_data    (extra_read_data)
  );

  // Register file: x0 hardwired to zero, read data registered one cycle after the address.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (extra_write_enable && extra_addr != 5'd0) rf[extra_addr] <= extra_write_data;
    extra_read_data <= (extra_addr == 5'd0) ? 32'd0 : rf[extra_addr];
  end

  int we_count = 0;
  always @(posedge clk) if (extra_write_enable) we_count <= we_count + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  addr;
    logic        err;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

  task automatic expect_beat(input logic [31:0] d, input logic [4:0] a, input logic e, input logic l);
    beat_t b;
    b.data = d; b.addr = a; b.err = e; b.last = l;
    exp_q.push_back(b);
  endtask

  // Monitor: every beat that will handshake at the next rising edge is popped and compared.
  beat_t mon_exp;
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      $display("beat addr=%0d data=%h err=%0d last=%0d", rsp_addr, rsp_data, rsp_error, rsp_last);
      check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("rsp_data",  64'(rsp_data),  64'(mon_exp.data));
        check("rsp_addr",  64'(rsp_addr),  64'(mon_exp.addr));
        check("rsp_error", 64'(rsp_error), 64'(mon_exp.err));
        check("rsp_last",  64'(rsp_last),  64'(mon_exp.last));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_cmd(input logic wr, input logic dmp, input logic [4:0] a, input logic [31:0] d);
    int n;
    n = 0;
    cmd_write = wr; cmd_dump = dmp; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_accept", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  int we0;
  int n_wait;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; core_halted = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_dump = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp",   {rsp_valid, rsp_data, rsp_addr, rsp_error, rsp_last}, 64'd0);
    check("reset_extra", {extra_addr, extra_write_enable, extra_write_data}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 64'(cmd_ready), 64'd1);

    // Halted write x5, then read it back.
    we0 = we_count;
    expect_beat(32'd0, 5'd5, 1'b0, 1'b1);
    send_cmd(1'b1, 1'b0, 5'd5, 32'hDEADBEEF);
    drain(50);
    check("we_pulse_x5", 64'(we_count - we0), 64'd1);
    expect_beat(32'hDEADBEEF, 5'd5, 1'b0, 1'b1);
    send_cmd(1'b0, 1'b0, 5'd5, 32'd0);
    drain(50);

    // Core running: read is refused, no write strobe.
    core_halted = 1'b0;
    we0 = we_count;
    expect_beat(32'd0, 5'd3, 1'b1, 1'b1);
    send_cmd(1'b0, 1'b0, 5'd3, 32'd0);
    drain(50);
    check("we_none_running", 64'(we_count - we0), 64'd0);
    core_halted = 1'b1;

    // x0 accepts the write without error but always reads zero.
    expect_beat(32'd0, 5'd0, 1'b0, 1'b1);
    send_cmd(1'b1, 1'b0, 5'd0, 32'h12345678);
    drain(50);
    expect_beat(32'd0, 5'd0, 1'b0, 1'b1);
    send_cmd(1'b0, 1'b0, 5'd0, 32'd0);
    drain(50);

    // Backpressure on a read of x7.
    expect_beat(32'd0, 5'd7, 1'b0, 1'b1);
    send_cmd(1'b1, 1'b0, 5'd7, 32'hA5A5A5A5);
    drain(50);
    rsp_ready = 1'b0;
    expect_beat(32'hA5A5A5A5, 5'd7, 1'b0, 1'b1);
    send_cmd(1'b0, 1'b0, 5'd7, 32'd0);
    n_wait = 0;
    while (!rsp_valid && n_wait < 20) begin
      @(posedge clk); #1;
      n_wait++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_data",  64'(rsp_data),  64'hA5A5A5A5);
      check("bp_ready", 64'(cmd_ready), 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_after", {rsp_valid, cmd_ready}, 64'b01);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

`ifdef RF_DEBUG_DUMP_EN
    // Fill xN = N*0x11 and dump the whole file.
    for (int i = 1; i < 32; i++) begin
      expect_beat(32'd0, 5'(i), 1'b0, 1'b1);
      send_cmd(1'b1, 1'b0, 5'(i), 32'(i * 17));
      drain(50);
    end
    for (int i = 0; i < 32; i++) expect_beat(32'(i * 17), 5'(i), 1'b0, (i == 31));
    send_cmd(1'b0, 1'b1, 5'd0, 32'd0);
    drain(400);
    check("dump_idle", 64'(cmd_ready), 64'd1);

    // Halt drops after the beat for x10: next beat aborts the dump.
    for (int i = 0; i < 11; i++) expect_beat(32'(i * 17), 5'(i), 1'b0, 1'b0);
    expect_beat(32'd0, 5'd11, 1'b1, 1'b1);
    send_cmd(1'b0, 1'b1, 5'd0, 32'd0);
    n_wait = 0;
    while (exp_q.size() != 1 && n_wait < 200) begin
      @(negedge clk); #1;
      n_wait++;
    end
    @(posedge clk); #1;
    core_halted = 1'b0;
    drain(50);
    check("abort_idle", 64'(cmd_ready), 64'd1);
    core_halted = 1'b1;
`else
    // Dump is not built: immediate error beat carrying the command address.
    expect_beat(32'd0, 5'd4, 1'b1, 1'b1);
    send_cmd(1'b0, 1'b1, 5'd4, 32'd0);
    drain(50);
`endif

    // Reset asserted during WRITE: strobe dies, register keeps its old value.
    expect_beat(32'd0, 5'd9, 1'b0, 1'b1);
    send_cmd(1'b1, 1'b0, 5'd9, 32'h11111111);
    drain(50);
    we0 = we_count;
    send_cmd(1'b1, 1'b0, 5'd9, 32'h22222222);
    check("we_in_write", 64'(extra_write_enable), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp",   {rsp_valid, rsp_data, rsp_addr, rsp_error, rsp_last}, 64'd0);
    check("midrst_extra", {extra_addr, extra_write_enable, extra_write_data}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("midrst_ready", 64'(cmd_ready), 64'd1);
    check("midrst_no_we", 64'(we_count - we0), 64'd0);
    @(posedge clk); #1;
    expect_beat(32'h11111111, 5'd9, 1'b0, 1'b1);
    send_cmd(1'b0, 1'b0, 5'd9, 32'd0);
    drain(50);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
